axi4l_reg_slave: RTL and testbench
==================================

Name: axi4l_reg_slave

Overview:
AXI4-Lite responder that terminates the S_AXI port of the HDMI SiL9134 controller and exposes a small bank of read/write control registers to the video/I2C logic. It accepts address and data channels in any order, applies byte strobes and returns OKAY responses. It is the register-side counterpart of the AXI4-Lite master BFM used in the block-design bench. It must pass the bench's sequential write/readback of 4 words at 4-byte stride.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
ACLK  in  1  system clock; all logic on the rising edge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  accepted and ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response; always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  accepted and ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response; always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  128  registers 3..0 concatenated; reg0 in [31:0]
reg_wr_pulse  out  4  one-cycle pulse per register on commit

Behaviour:
- Reset (ARESET=1 at the clock edge):
  - All ready and valid outputs go to 0.
  - BRESP, RRESP and RDATA go to 0.
  - All four registers and reg_wr_pulse go to 0.
  - Held AW/W state is cleared.
  - Applies mid-transaction: any pending AW, W, B or R is dropped. The master must restart.
- Write path: two independent capture slots, aw_held and w_held.
  - AWREADY = !aw_held && !BVALID && !ARESET.
  - WREADY = !w_held && !BVALID && !ARESET.
  - An AW handshake latches AWADDR[3:2]. A W handshake latches WDATA/WSTRB.
  - Commit happens on the edge where both an address and data are available, each either held or handshaking that cycle. Order is AW first, W first, or both in the same cycle.
  - At commit:
    - Only byte lanes with WSTRB[i]=1 are updated.
    - reg_wr_pulse[idx]=1 for exactly one cycle.
    - Both held flags clear.
    - BVALID=1.
  - Latency: same-cycle AW+W handshake gives BVALID on the next cycle. New register contents appear on reg_out in that same cycle.
  - BVALID stays high until the BVALID&&BREADY edge, then drops. AW/W readiness returns in the following cycle, so at most 1 outstanding write.
  - WSTRB=0 still commits, produces a pulse and returns OKAY; no data bits change.
- Read path:
  - ARREADY = !RVALID && !ARESET.
  - On an AR handshake, RDATA is registered from register ARADDR[3:2] using the value before that edge, and RVALID=1 on the next cycle.
  - RVALID and RDATA stay stable until the RVALID&&RREADY edge. RVALID then drops; RDATA keeps its last value.
- Read and write paths are fully independent.
  - A read accepted on the same edge as a write commit to the same register returns the old value.
  - The next read returns the new value.
- Address bits [1:0] are ignored; unaligned addresses map to the containing word. There are no error responses.

Test Plan:
- Bench sequence: same-cycle AW+W of 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read -> BRESP=0, RRESP=0, readback matches each value, reg_wr_pulse = 1, 2, 4, 8 in turn.
- W leads AW by 3 cycles (data 0x12345678 to 0x4), with BREADY low for 5 cycles -> WREADY drops after the W handshake; BVALID is held for 5 cycles with AWREADY/WREADY=0; reg1=0x12345678.
- reg2 holds 0xDEAD0011; write 0xFFFFFFFF to 0x8 with WSTRB=4'b0101 -> reg2=0xDEFF00FF.
- Read 0xC with RREADY low for 4 cycles -> RVALID and RDATA held stable, ARREADY=0 throughout, single beat delivered.
- A read of 0x0 accepted on the same edge as a write commit of 0xCAFEF00D to 0x0 -> RDATA = old value; an immediate second read returns 0xCAFEF00D.
- Assert ARESET while BVALID=1 and while RVALID=1 -> next cycle all valids/readies = 0, reg_out=0, reg_wr_pulse=0; a fresh write then completes normally.

Source files
------------

// File: rtl/axi4l_reg_slave_if.sv
// AXI4-Lite channel bundle between a bus master and the register slave.
interface axi4l_reg_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite responder exposing four 32-bit control registers with byte strobes.
// AW and W may arrive in any order; one write and one read may be in flight.
module axi4l_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    axi4l_reg_slave_if.slave                s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [3:0]                      reg_wr_pulse
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NUM_REGS = 4;

    logic          aw_held_q, aw_held_d;
    logic [1:0]    aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [3:0]    w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [1:0]    wr_idx;
    logic [DW-1:0] wr_data, wr_mask;
    logic [3:0]    wr_strb;
    logic          unused_ok;

    assign s_axi.S_AXI_AWREADY = !aw_held_q && !bvalid_q && !ARESET;
    assign s_axi.S_AXI_WREADY  = !w_held_q && !bvalid_q && !ARESET;
    assign s_axi.S_AXI_ARREADY = !rvalid_q && !ARESET;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

    assign reg_out      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
    assign reg_wr_pulse = pulse_q;

    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Each half of a write comes from its held slot if already captured, else from the live bus.
    always_comb begin
        wr_idx  = aw_held_q ? aw_idx_q : s_axi.S_AXI_AWADDR[3:2];
        wr_data = w_held_q ? w_data_q : s_axi.S_AXI_WDATA;
        wr_strb = w_held_q ? w_strb_q : s_axi.S_AXI_WSTRB;
        commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        for (int b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        end

        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        pulse_d   = 4'b0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
            w_strb_d = s_axi.S_AXI_WSTRB;
        end
        if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d       = 1'b0;
            w_held_d        = 1'b0;
            bvalid_d        = 1'b1;
            pulse_d[wr_idx] = 1'b1;
            regs_d[wr_idx]  = (regs_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[s_axi.S_AXI_ARADDR[3:2]];
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= 2'b00;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= 4'b0000;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            pulse_q   <= 4'b0000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end
endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Scoreboard bench for axi4l_reg_slave: drivers push expected B/R/pulse results,
// a negedge monitor pops and compares them as the DUT presents each response.
module tb_axi4l_reg_slave;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         arst;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    axi4l_reg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    axi4l_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK        (clk),
        .ARESET      (arst),
        .s_axi       (bus.slave),
        .reg_out     (reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    int           compared   = 0;
    int           mismatched = 0;
    logic [31:0]  model [4];
    logic [31:0]  exp_r_q [$];
    logic [127:0] exp_b_q [$];
    logic [3:0]   exp_pulse_q [$];

    function automatic void check_output(input string name, input logic [127:0] actual,
                                         input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    // Reference byte-lane merge: each enabled byte comes from the new data.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [7:0] bytes [4];
        for (int b = 0; b < 4; b++) begin
            bytes[b] = strb[b] ? 8'((data >> (8 * b)) & 32'hFF) : 8'((old >> (8 * b)) & 32'hFF);
        end
        return {bytes[3], bytes[2], bytes[1], bytes[0]};
    endfunction

    function automatic logic [127:0] model_image();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic chan_ready(input int ch);
        case (ch)
            0:       return bus.S_AXI_AWREADY;
            1:       return bus.S_AXI_WREADY;
            2:       return bus.S_AXI_ARREADY;
            3:       return bus.S_AXI_BVALID;
            default: return bus.S_AXI_RVALID;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int ch, input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(negedge clk);
            if (chan_ready(ch)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output({name, "_timeout"}, 0, 1);
    endtask

    // Response monitor: every handshake or pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!arst) begin
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                check_output("b_expected", exp_b_q.size() != 0, 1);
                check_output("bresp", bus.S_AXI_BRESP, 0);
                if (exp_b_q.size() != 0) check_output("reg_out_at_b", reg_out, exp_b_q.pop_front());
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                check_output("r_expected", exp_r_q.size() != 0, 1);
                check_output("rresp", bus.S_AXI_RRESP, 0);
                if (exp_r_q.size() != 0) check_output("rdata", bus.S_AXI_RDATA, exp_r_q.pop_front());
            end
            if (reg_wr_pulse != 4'b0000) begin
                check_output("pulse_expected", exp_pulse_q.size() != 0, 1);
                if (exp_pulse_q.size() != 0) check_output("reg_wr_pulse", reg_wr_pulse, exp_pulse_q.pop_front());
            end
        end
    end

    // w_lead > 0: W issued that many cycles before AW; w_lead < 0: AW leads.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int b_delay);
        logic [1:0] idx;
        bit ok_aw, ok_w, ok_b;
        idx = addr[3:2];
        model[idx] = merge(model[idx], data, strb);
        exp_pulse_q.push_back(4'b0001 << idx);
        exp_b_q.push_back(model_image());
        bus.S_AXI_BREADY = (b_delay == 0);
        fork
            begin
                repeat (w_lead > 0 ? w_lead : 0) tick();
                bus.S_AXI_AWADDR  = addr;
                bus.S_AXI_AWPROT  = 3'($urandom);
                bus.S_AXI_AWVALID = 1'b1;
                wait_for(0, "awready", ok_aw);
                tick();
                bus.S_AXI_AWVALID = 1'b0;
            end
            begin
                repeat (w_lead < 0 ? -w_lead : 0) tick();
                bus.S_AXI_WDATA  = data;
                bus.S_AXI_WSTRB  = strb;
                bus.S_AXI_WVALID = 1'b1;
                wait_for(1, "wready", ok_w);
                tick();
                bus.S_AXI_WVALID = 1'b0;
                if (ok_w && w_lead > 0) begin
                    @(negedge clk);
                    check_output("wready_after_w", bus.S_AXI_WREADY, 0);
                end
            end
        join
        wait_for(3, "bvalid", ok_b);
        if (ok_b) begin
            for (int i = 0; i < b_delay; i++) begin
                check_output("bvalid_held", bus.S_AXI_BVALID, 1);
                check_output("awready_during_b", bus.S_AXI_AWREADY, 0);
                check_output("wready_during_b", bus.S_AXI_WREADY, 0);
                if (i < b_delay - 1) @(negedge clk);
            end
            if (b_delay > 0) begin
                tick();
                bus.S_AXI_BREADY = 1'b1;
                @(negedge clk);
            end
            tick();
            bus.S_AXI_BREADY = 1'b0;
            @(negedge clk);
            check_output("bvalid_drop", bus.S_AXI_BVALID, 0);
            check_output("awready_return", bus.S_AXI_AWREADY, 1);
        end
        bus.S_AXI_BREADY = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [3:0] addr, input int r_delay, input logic [31:0] exp_data);
        bit ok;
        exp_r_q.push_back(exp_data);
        bus.S_AXI_RREADY  = (r_delay == 0);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARPROT  = 3'($urandom);
        bus.S_AXI_ARVALID = 1'b1;
        wait_for(2, "arready", ok);
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        if (ok) wait_for(4, "rvalid", ok);
        if (ok) begin
            for (int i = 0; i < r_delay; i++) begin
                check_output("rvalid_held", bus.S_AXI_RVALID, 1);
                check_output("rdata_held", bus.S_AXI_RDATA, exp_data);
                check_output("arready_during_r", bus.S_AXI_ARREADY, 0);
                if (i < r_delay - 1) @(negedge clk);
            end
            if (r_delay > 0) begin
                tick();
                bus.S_AXI_RREADY = 1'b1;
                @(negedge clk);
            end
            tick();
            bus.S_AXI_RREADY = 1'b0;
            @(negedge clk);
            check_output("rvalid_drop", bus.S_AXI_RVALID, 0);
            check_output("rdata_kept", bus.S_AXI_RDATA, exp_data);
        end
        bus.S_AXI_RREADY = 1'b0;
        tick();
    endtask

    task automatic apply_reset_during_responses();
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        exp_pulse_q.push_back(4'b0100);
        bus.S_AXI_AWADDR  = 4'h8;
        bus.S_AXI_WDATA   = 32'h600DF00D;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_ARADDR  = 4'h4;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check_output("pre_reset_bvalid", bus.S_AXI_BVALID, 1);
        check_output("pre_reset_rvalid", bus.S_AXI_RVALID, 1);
        tick();
        arst = 1'b1;
        tick();
        @(negedge clk);
        check_output("rst_bvalid", bus.S_AXI_BVALID, 0);
        check_output("rst_rvalid", bus.S_AXI_RVALID, 0);
        check_output("rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 0);
        check_output("rst_reg_out", reg_out, 0);
        check_output("rst_pulse", reg_wr_pulse, 0);
        check_output("rst_rdata", bus.S_AXI_RDATA, 0);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        exp_b_q.delete();
        exp_r_q.delete();
        tick();
        arst = 1'b0;
        @(negedge clk);
        check_output("post_reset_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] plan_data [4];
        logic [31:0] old0;
        logic [3:0]  ra;
        plan_data[0] = 32'h0101FFFF;
        plan_data[1] = 32'hABCD0001;
        plan_data[2] = 32'hDEAD0011;
        plan_data[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        arst = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_output("init_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 0);
        check_output("init_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);
        check_output("init_reg_out", reg_out, 0);
        check_output("init_pulse", reg_wr_pulse, 0);
        tick();
        arst = 1'b0;
        @(negedge clk);
        check_output("idle_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        tick();

        $display("[TB] sequential write/readback of four words");
        for (int k = 0; k < 4; k++) begin
            do_write(4'(4 * k), plan_data[k], 4'hF, 0, 0);
            do_read(4'(4 * k), 0, model[k]);
            check_output("plan_reg", reg_out[32*k +: 32], plan_data[k]);
        end

        $display("[TB] W leads AW, BREADY held low");
        do_write(4'h4, 32'h12345678, 4'hF, 3, 5);
        check_output("reg1_after_wlead", reg_out[63:32], 32'h12345678);

        $display("[TB] partial strobe write");
        do_write(4'h8, 32'hFFFFFFFF, 4'b0101, 0, 0);
        check_output("reg2_strobed", reg_out[95:64], 32'hDEFF00FF);

        $display("[TB] read with RREADY held low");
        do_read(4'hC, 4, model[3]);

        $display("[TB] AW leads W, unaligned address, empty strobe");
        do_write(4'h3, 32'h55AA55AA, 4'b1100, -2, 1);
        check_output("reg0_unaligned", reg_out[31:0], 32'h55AAFFFF);
        do_write(4'h5, 32'hFFFFFFFF, 4'b0000, 0, 0);
        check_output("reg1_strb0", reg_out[63:32], 32'h12345678);

        $display("[TB] read racing a commit to the same register");
        old0 = model[0];
        fork
            do_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0);
            do_read(4'h0, 0, old0);
        join
        do_read(4'h0, 0, model[0]);
        check_output("reg0_new", reg_out[31:0], 32'hCAFEF00D);

        $display("[TB] reset during outstanding responses");
        apply_reset_during_responses();
        do_write(4'hC, 32'h13579BDF, 4'hF, 0, 0);
        do_read(4'hC, 0, model[3]);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 60; n++) begin
            ra = 4'($urandom);
            if ($urandom_range(1) == 0) begin
                do_write(ra, $urandom, 4'($urandom), int'($urandom_range(6)) - 3, int'($urandom_range(3)));
            end else begin
                do_read(ra, int'($urandom_range(3)), model[ra[3:2]]);
            end
        end

        repeat (4) tick();
        check_output("b_left_over", exp_b_q.size(), 0);
        check_output("r_left_over", exp_r_q.size(), 0);
        check_output("pulse_left_over", exp_pulse_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
